bp_pht_controller: RTL
======================

Name: bp_pht_controller

Overview:
- Sequencer and owner of a gshare-style pattern history table (PHT) of 2-bit saturating branch predictors. It replaces per-branch standalone predictor instances with one shared table.
- Walks the table to initialise it after reset or flush. It then serves one lookup and one resolved-branch update per cycle, and maintains the global history register (GHR) and a misprediction counter.
- Sits between fetch (lookup) and execute/branch resolution (update).

Parameters:
IDX_W, 4, table index width; table depth = 2**IDX_W entries
INIT_STATE, 2'b01, counter value written by init walk (weakly not-taken)
CNT_W, 8, width of mispredict counter

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  pulse; re-initialises table and GHR
lookup_valid  in  1  fetch requests a prediction this cycle
lookup_pc  in  IDX_W  low PC bits of branch
predict_valid  out  1  prediction result valid
predict  out  1  1 = predict taken
predict_idx  out  IDX_W  table index used; returned by execute on update
update_valid  in  1  resolved branch update request
update_ready  out  1  controller accepts updates this cycle
update_idx  in  IDX_W  index returned from predict_idx
update_taken  in  1  actual branch outcome
update_predicted  in  1  prediction that was used for this branch
busy  out  1  init walk in progress
mispredict_cnt  out  CNT_W  saturating count of mispredictions

Behaviour:
- One clock; reset is synchronous and active-high; port names clk and reset.
- Reset values:
  - Outputs: predict_valid=0, predict=0, predict_idx=0, busy=1, update_ready=0, mispredict_cnt=0.
  - Internal: GHR=0, init pointer=0, FSM=INIT.
- FSM states: INIT, RUN.
  - INIT: writes INIT_STATE to entry ptr each cycle, ptr increments. After writing entry 2**IDX_W-1, next state is RUN.
  - busy=1 for exactly 2**IDX_W cycles after reset release (16 for defaults), then 0.
  - RUN: stays in RUN until flush or reset.
- update_ready = (state==RUN), registered, so it equals ~busy.
- While busy:
  - lookup_valid is ignored; predict_valid=0.
  - Updates are not accepted; the requester holds update_valid until update_ready.
- Lookup in RUN, 1-cycle latency:
  - idx = lookup_pc XOR GHR.
  - Next cycle: predict_valid=1, predict = entry[idx][1], predict_idx = idx.
  - predict_valid=0 in any cycle following no lookup.
- Update, when update_valid & update_ready:
  - Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - Taken: entry[update_idx] increments, saturating at 11.
  - Not taken: entry[update_idx] decrements, saturating at 00.
  - GHR <= {GHR[IDX_W-2:0], update_taken}.
  - If update_predicted != update_taken, mispredict_cnt increments, saturating at 2**CNT_W-1 (no wrap).
- Lookup and update in the same cycle:
  - Lookup uses pre-update table contents and pre-update GHR (read-before-write), including when both target the same index.
  - The update still commits.
- Flush:
  - In RUN: next cycle state=INIT, ptr=0, GHR=0, busy=1, predict_valid=0. Any lookup or update in the flush cycle is discarded.
  - During INIT: restarts the walk at ptr=0.
  - Flush does not clear mispredict_cnt.
- Reset mid-operation: returns everything to reset values immediately at the edge. Reset dominates flush.
- All index arithmetic is modulo 2**IDX_W. The ptr wrap after the last entry is not used, since the FSM leaves INIT.

Decomposition:
- Shared package bp_pkg:
  - Counter encoding constants SNT/WNT/WT/ST.
  - FSM state encodings INIT/RUN.
  - Saturating next-counter function (counter, taken) -> counter.
- Sub-module bp_pht: 2**IDX_W x 2-bit storage with one synchronous read port and one write port.
  - Read returns old data on same-address write.
  - Write is muxed by the controller between the init walk and update.
- The controller holds the FSM, GHR, output registers and mispredict counter.

Test Plan:
- Reset 1 cycle then release, lookup_valid=1 every cycle -> busy=1 and predict_valid=0 for 16 cycles; first predict_valid=1 carries predict=0 (WNT) for any pc.
- After init, 3 updates idx=5 taken=1 (predicted 0,1,1; update_predicted=0 on the first), then hold GHR at 0 (flush disabled, GHR effect checked via predict_idx) -> lookup at idx 5 yields predict=1. Entry saturates at 11, checked by 3 subsequent not-taken updates needing 2 before predict=0.
- GHR: updates taken,taken,not-taken -> GHR=4'b0110; lookup_pc=4'b0011 -> predict_idx=4'b0101 one cycle later.
- Same-cycle lookup and update to the same index, entry=01, update taken -> predict=0 (old value); following lookup -> predict=1.
- Flush in RUN after mispredict_cnt=3 -> busy=1 for 16 cycles, update_ready=0, GHR=0, all entries read back as WNT, mispredict_cnt still 3.
- 2**CNT_W+2 updates with update_predicted!=update_taken -> mispredict_cnt saturates at 255, no wrap. A reset during the init walk at ptr=7 -> walk restarts with busy=1 for a full 16 cycles.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: counter encodings, FSM states and the saturating counter step shared by the PHT controller.
package bp_pkg;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;

   function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
      return taken ? ((cnt == ST) ? ST : cnt + 2'd1) : ((cnt == SNT) ? SNT : cnt - 2'd1);
   endfunction

endpackage

// File: rtl/bp_pht.sv
// bp_pht: 2**IDX_W x 2-bit predictor storage, one synchronous read port (old data on collision) and one write port.
module bp_pht import bp_pkg::*; #(
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [1:0]       rd_data,
   input  logic             we,
   input  logic             wr_init,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [1:0]       wr_data,
   input  logic             wr_taken
);

   logic [1:0] mem [2**IDX_W];
   logic [1:0] rd_data_q, rd_data_d;

   always_comb rd_data_d = mem[rd_idx];

   // the update step is applied in place so the lookup port stays free for fetch
   always_ff @(posedge clk) begin
      rd_data_q <= rd_data_d;
      if (we) mem[wr_idx] <= wr_init ? wr_data : sat_next(mem[wr_idx], wr_taken);
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/bp_pht_controller.sv
// bp_pht_controller: gshare PHT sequencer -- init walk, lookup/update arbitration, GHR and mispredict count.
module bp_pht_controller import bp_pkg::*; #(
   parameter int         IDX_W      = 4,
   parameter logic [1:0] INIT_STATE = WNT,
   parameter int         CNT_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             lookup_valid,
   input  logic [IDX_W-1:0] lookup_pc,
   output logic             predict_valid,
   output logic             predict,
   output logic [IDX_W-1:0] predict_idx,
   input  logic             update_valid,
   output logic             update_ready,
   input  logic [IDX_W-1:0] update_idx,
   input  logic             update_taken,
   input  logic             update_predicted,
   output logic             busy,
   output logic [CNT_W-1:0] mispredict_cnt
);

   localparam logic [IDX_W-1:0] LAST    = '1;
   localparam logic [IDX_W-1:0] PTR_ONE = IDX_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d, ghr_q, ghr_d, pidx_q, pidx_d, look_idx;
   logic [CNT_W-1:0] mis_q, mis_d;
   logic             pv_q, pv_d, look_fire, upd_fire, walking;
   logic [1:0]       rd_data;

   // a flush cycle swallows any lookup or update presented with it
   always_comb begin
      walking   = (state_q == INIT);
      look_idx  = lookup_pc ^ ghr_q;
      look_fire = !walking && lookup_valid && !flush;
      upd_fire  = !walking && update_valid && !flush;
      state_d   = flush ? INIT : (walking && ptr_q == LAST) ? RUN : state_q;
      ptr_d     = (flush || !walking) ? '0 : ptr_q + PTR_ONE;
      ghr_d     = flush ? '0 : upd_fire ? {ghr_q[IDX_W-2:0], update_taken} : ghr_q;
      pv_d      = look_fire;
      pidx_d    = look_fire ? look_idx : pidx_q;
      mis_d     = (upd_fire && update_taken != update_predicted && mis_q != '1) ? mis_q + CNT_ONE : mis_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= INIT;
         ptr_q   <= '0;
         ghr_q   <= '0;
         pv_q    <= 1'b0;
         pidx_q  <= '0;
         mis_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         ghr_q   <= ghr_d;
         pv_q    <= pv_d;
         pidx_q  <= pidx_d;
         mis_q   <= mis_d;
      end
   end

   bp_pht #(.IDX_W(IDX_W)) u_pht (
      .clk      (clk),
      .rd_idx   (look_idx),
      .rd_data  (rd_data),
      .we       (walking || upd_fire),
      .wr_init  (walking),
      .wr_idx   (walking ? ptr_q : update_idx),
      .wr_data  (INIT_STATE),
      .wr_taken (update_taken)
   );

   assign predict_valid  = pv_q;
   assign predict        = pv_q & rd_data[1];
   assign predict_idx    = pidx_q;
   assign busy           = walking;
   assign update_ready   = !walking;
   assign mispredict_cnt = mis_q;

endmodule
